// File: rtl/array2d_regfile.sv
// array2d_regfile: ROWS x COLS register array with a one-cycle registered read
// port, one write port, and a row-clear engine that zeroes one column per cycle.
// Illegal requests (out-of-range indices, writes while clearing) set a sticky err.

module array2d_regfile #(
    parameter  int WIDTH = 8,
    parameter  int ROWS  = 4,
    parameter  int COLS  = 4,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [RW-1:0]    wr_row,
    input  logic [CW-1:0]    wr_col,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [RW-1:0]    rd_row,
    input  logic [CW-1:0]    rd_col,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr_en,
    input  logic [RW-1:0]    clr_row,
    output logic             busy,
    output logic             err
);

    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem [ROWS][COLS];

    state_t        state;
    state_t        next_state;
    logic [RW-1:0] clr_row_q;
    logic [CW-1:0] col_cnt;
    logic          clr_start;
    logic          clr_bad;

    // Index range checks; only non-power-of-two sizes can ever fail them.
    logic wr_ok, rd_ok, clr_row_ok;
    logic wr_do, err_set;

    assign wr_ok      = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign rd_ok      = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
    assign clr_row_ok = (int'(clr_row) < ROWS);

    assign busy    = (state == CLEAR);
    assign wr_do   = wr_en && !busy && wr_ok;
    assign err_set = (wr_en && (busy || !wr_ok)) || (rd_en && !rd_ok) || clr_bad;

    // Next-state logic for the row-clear sequencer.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        clr_start  = 1'b0;
        clr_bad    = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_en) begin
                    if (clr_row_ok) begin
                        next_state = CLEAR;
                        clr_start  = 1'b1;
                    end else begin
                        clr_bad = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (col_cnt == LAST_COL) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register, latched clear row and column counter.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clr_row_q <= '0;
            col_cnt   <= '0;
        end else begin
            state <= next_state;
            if (clr_start) begin
                clr_row_q <= clr_row;
                col_cnt   <= '0;
            end else if (state == CLEAR) begin
                col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
            end
        end
    end

    // Array storage: reset, accepted writes, and one zeroed column per CLEAR cycle.
    // NOTE: the array is reset because reads after rst must return 0; this
    // forces flops instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else begin
            if (wr_do) mem[wr_row][wr_col] <= wr_data;
            if (busy)  mem[clr_row_q][col_cnt] <= '0;
        end
    end

    // Registered read port; reads the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_ok ? mem[rd_row][rd_col] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)          err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

endmodule

// File: tb/tb_array2d_regfile.sv
// Testbench for array2d_regfile (WIDTH=8, ROWS=4, COLS=4). Read requests push
// their expected data and return cycle into a queue; a negedge monitor pops and
// compares whenever a read result is due.

module tb_array2d_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [1:0] wr_col;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [1:0] rd_row;
    logic [1:0] rd_col;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       clr_en;
    logic [1:0] clr_row;
    logic       busy;
    logic       err;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    array2d_regfile #(.WIDTH(8), .ROWS(4), .COLS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .clr_en  (clr_en),
        .clr_row (clr_row),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Count rising edges so the monitor can verify read latency.
    always @(posedge clk) cyc_cnt++;

    // Monitor: a due read must be presented with the expected data; any other
    // rd_valid pulse is unexpected.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc_cnt) begin
            e = q.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e.data) begin
                errors++;
                $display("FAIL read@%0d: rd_valid=%b rd_data=%02h, required rd_valid=1 rd_data=%02h",
                         cyc_cnt, rd_valid, rd_data, e.data);
            end
        end else if (rd_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_valid@%0d: rd_valid=%b, required 0", cyc_cnt, rd_valid);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int r, input int c, input logic [7:0] d);
        wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int r, input int c, input logic [7:0] d);
        exp_t e;
        rd_en = 1'b1; rd_row = 2'(r); rd_col = 2'(c);
        e.data = d;
        e.cyc  = cyc_cnt + 1;
        q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic start_clear(input int r);
        clr_en = 1'b1; clr_row = 2'(r);
        tick();
        clr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_en = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0; rd_row = '0; rd_col = '0; clr_row = '0;
        repeat (2) tick();
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        rst = 1'b0;

        // Basic write then read.
        do_write(2, 3, 8'hA5);
        do_read(2, 3, 8'hA5);
        tick();
        check("basic_err", err, 0);

        // Fill the array, then stream every element back.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                do_write(r, c, 8'(16 * r + c));
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                do_read(r, c, 8'(16 * r + c));
        tick();

        // Same-cycle read and write of one element returns the old value.
        do_write(1, 1, 8'h22);
        wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd1; wr_data = 8'h11;
        do_read(1, 1, 8'h22);
        wr_en = 1'b0;
        do_read(1, 1, 8'h11);

        // Row clear: busy for exactly 4 cycles; same-cycle reads see pre-clear data;
        // a clr_en while busy is ignored without error.
        for (int c = 0; c < 4; c++) do_write(1, c, 8'hFF);
        start_clear(1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("clear_busy_%0d", k), busy, 1);
            if (k == 1) begin
                clr_en = 1'b1; clr_row = 2'd2;
            end
            do_read(1, k, 8'hFF);
            clr_en = 1'b0;
        end
        check("clear_done_busy", busy, 0);
        check("clear_err", err, 0);
        for (int c = 0; c < 4; c++) do_read(1, c, 8'h00);
        for (int r = 0; r < 4; r++)
            if (r != 1)
                for (int c = 0; c < 4; c++)
                    do_read(r, c, 8'(16 * r + c));
        tick();
        check("clear_ignored_err", err, 0);

        // Write and clear together: write lands first, clear wins on the same row.
        wr_en = 1'b1; wr_row = 2'd3; wr_col = 2'd0; wr_data = 8'h77;
        start_clear(3);
        wr_en = 1'b0;
        wait_idle();
        do_read(3, 0, 8'h00);
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h99;
        start_clear(3);
        wr_en = 1'b0;
        wait_idle();
        do_read(0, 0, 8'h99);
        do_read(3, 1, 8'h00);
        tick();
        check("wr_clr_err", err, 0);

        // Write while busy is dropped and sets a sticky err; rst clears everything.
        start_clear(2);
        do_write(0, 1, 8'h5A);
        check("busy_write_err", err, 1);
        wait_idle();
        do_read(0, 1, 8'h01);
        repeat (3) tick();
        check("err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_after_rst", err, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                do_read(r, c, 8'h00);
        tick();

        // Reset in cycle 2 of a CLEAR abandons it; requests during rst are ignored.
        do_write(0, 0, 8'h12);
        do_write(3, 3, 8'h34);
        do_write(0, 2, 8'h56);
        start_clear(0);
        tick();
        check("clear_cycle2_busy", busy, 1);
        rst = 1'b1;
        wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd1; wr_data = 8'hEE;
        rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd2;
        clr_en = 1'b1; clr_row = 2'd1;
        tick();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_en = 1'b0;
        check("rst_clear_busy", busy, 0);
        check("rst_clear_rd_valid", rd_valid, 0);
        tick();
        check("rst_clear_busy_after", busy, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                do_read(r, c, 8'h00);
        repeat (3) tick();
        check("final_err", err, 0);
        check("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/array2d_regfile.md
ARRAY2D_REGFILE -- requirements
Module: array2d_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of one array element.
REQ-002 SHALL have parameter ROWS, default 4, first unpacked dimension, ROWS >= 2.
REQ-003 SHALL have parameter COLS, default 4, second unpacked dimension, COLS >= 2.
REQ-004 SHALL have localparams RW = $clog2(ROWS) and CW = $clog2(COLS), the row and column index widths.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_row  input  RW  write row index.
REQ-009 wr_col  input  CW  write column index.
REQ-010 wr_data  input  WIDTH  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 rd_row  input  RW  read row index.
REQ-013 rd_col  input  CW  read column index.
REQ-014 rd_data  output  WIDTH  registered read data.
REQ-015 rd_valid  output  1  rd_data holds the result of the previous cycle's read.
REQ-016 clr_en  input  1  request to clear one whole row.
REQ-017 clr_row  input  RW  row to clear.
REQ-018 busy  output  1  a row-clear sequence is in progress.
REQ-019 err  output  1  sticky error flag.

Function
REQ-020 SHALL store ROWS x COLS elements of WIDTH bits as a two-dimensional unpacked array.
REQ-021 Write: wr_en=1, busy=0 and both indices in range -> element[wr_row][wr_col] <= wr_data at the next edge.
REQ-022 Read: rd_en=1 -> rd_data <= element[rd_row][rd_col] and rd_valid <= 1 at the next edge (latency 1).
REQ-023 rd_en=0 -> rd_valid <= 0 and rd_data holds its value.
REQ-024 Read and write to the same element in the same cycle SHALL return the old contents (read-before-write).
REQ-025 Out-of-range index (row >= ROWS or col >= COLS, possible only for non-power-of-2 sizes):
- the write SHALL be dropped and err set;
- the read SHALL return 0 with rd_valid=1 and set err.
REQ-026 State machine states: IDLE and CLEAR; busy=1 only in CLEAR.
REQ-027 IDLE -> CLEAR when clr_en=1 and clr_row is in range:
- latch clr_row;
- reset the column counter to 0.
REQ-028 clr_en=1 with clr_row out of range SHALL set err and remain in IDLE.
REQ-029 In CLEAR, each cycle SHALL zero element[latched row][counter] and increment the counter; after column COLS-1 the next state SHALL be IDLE, so a clear takes exactly COLS cycles.
REQ-030 clr_en while busy=1 SHALL be ignored, without setting err.
REQ-031 wr_en while busy=1 SHALL be dropped and set err.
REQ-032 Reads SHALL proceed during CLEAR; a read of an element zeroed in the same cycle SHALL return the pre-clear value.
REQ-033 clr_en and wr_en asserted together in IDLE: the write SHALL complete, then CLEAR starts; if both target the same row, the cleared value wins.
REQ-034 err SHALL remain 1 once set until rst.

Reset
REQ-035 rst=1 at an edge SHALL zero all elements and force rd_data=0, rd_valid=0, busy=0, err=0, state IDLE and counter 0.
REQ-036 rst SHALL take priority over every concurrent request, including an in-progress CLEAR, which is abandoned.
REQ-037 Requests presented in the cycle rst=1 SHALL have no effect.

Verification (defaults WIDTH=8, ROWS=4, COLS=4)
REQ-038 Write 0xA5 to [2][3], then read [2][3] -> next cycle rd_data=0xA5, rd_valid=1; err=0.
REQ-039 Fill all 16 elements with value 16*r+c, then read all in a back-to-back rd_en stream -> each value returned exactly one cycle after its request.
REQ-040 Same-cycle write 0x11 and read of [1][1] holding 0x22 -> read returns 0x22; a following read returns 0x11.
REQ-041 Fill row 1 with 0xFF, pulse clr_en with clr_row=1 -> busy=1 for 4 cycles, then row 1 reads all 0 and rows 0, 2 and 3 are unchanged.
REQ-042 Write during busy -> write dropped, err=1 and held; a later rst -> err=0 and all reads return 0.
REQ-043 Assert rst during cycle 2 of a CLEAR -> next cycle busy=0, rd_valid=0 and all elements are 0.
